regfile_wr_demux: RTL and testbench
===================================

# regfile_wr_demux

Write side of the 32 x WIDTH integer register file. It accepts writeback requests over a valid/ready handshake and buffers them in a 2-entry in-order queue. Each commit is steered to exactly one register through a 5-to-32 one-hot decode. All register contents are exposed on a flat bus that feeds the read-port 32:1 selectors, and a per-register pending vector is exported so the hazard logic can stall reads of registers that have queued writes.

## Interface
- WIDTH, 32, register width in bits
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- wr_valid  in  1  writeback request valid
- wr_ready  out  1  queue can accept; high when count < 2
- wr_addr  in  5  destination register index
- wr_data  in  WIDTH  write data
- hold  in  1  when 1, no commit this cycle; requests may still enqueue
- regs_flat  out  32*WIDTH  register i at [i*WIDTH +: WIDTH]; slice 0 is always 0
- pending  out  32  bit i = 1 when any valid queue entry targets register i; bit 0 is always 0
- busy  out  1  count != 0

## Operation
- Accept: the request is taken when wr_valid && wr_ready at a rising edge.
  - wr_addr == 0: request is accepted (handshake completes) and dropped; it is never enqueued.
  - Otherwise, {addr, data} is appended at the queue tail.
- Queue: 2 entries, FIFO order, with head/tail pointers (1 bit each, wrapping) and a 2-bit count (0..2).
- Commit: at each edge where count > 0 && !hold, the head entry is written into register regs[head.addr] via the one-hot decode. The head pointer advances and count decrements.
- Simultaneous accept and commit: count is unchanged and pointers both advance. This is legal at count 1. At count 2, wr_ready = 0, so a simultaneous accept cannot occur.
- Same register written twice in the queue: commits happen in order, so the later data wins.
- wr_ready is combinational from count only. It does not depend on hold or on the commit in the same cycle.
- pending is combinational: OR over valid entries of the one-hot decode of each entry's addr.
- Register 0: storage is not implemented; its slice is tied to 0.
- Reset (rst_n low at an edge, including mid-operation): all registers clear to 0, count = 0, pointers = 0. Any queued writes are discarded.
- Reset values of outputs: regs_flat = 0, pending = 0, busy = 0, wr_ready = 1.

## Timing
- Request accepted at edge N with count 0 and hold 0 during cycle N+1:
  - pending[addr] and busy are high during cycle N+1.
  - The write commits at edge N+1, so the new value appears on regs_flat after edge N+1.
  - pending[addr] clears after edge N+1 unless another entry targets the same register.
- Minimum latency from accept to visible value: 1 cycle. Maximum: 1 + number of held cycles + 1 cycle per older entry ahead of it.
- Throughput: 1 write per cycle sustained while hold = 0.
- hold raised while count = 2: wr_ready stays 0 until the first commit edge after hold falls.
- No combinational path from wr_valid, wr_addr or wr_data to any output.

## Structure
- Package regfile_pkg holds:
  - constants: REG_COUNT = 32, REG_ADDR_W = 5, XLEN = 32
  - typedef wq_entry_t holding addr and data
- Sub-module dec5to32: combinational 5-bit to 32-bit one-hot decoder.
  - One instance drives the commit enables.
  - Two more instances generate pending, one per queue entry, each gated by that entry's valid bit.
- Storage is 31 registers of WIDTH bits, registers 1..31.

## Test plan
- Reset, then write addr 5, data 0xDEADBEEF with hold 0 → pending[5] = 1 for one cycle; regs_flat[5] = 0xDEADBEEF one cycle after accept; all other registers stay 0.
- Write addr 0, data 0xFFFFFFFF → handshake completes, busy stays 0, pending = 0, regs_flat slice 0 = 0.
- hold = 1, write addr 3 = 0x1 then addr 3 = 0x2 → wr_ready = 0 after the second accept and pending[3] = 1. Release hold → regs[3] = 0x1 then 0x2 on consecutive edges; wr_ready = 1 after the first commit.
- hold = 0, back-to-back writes to addr 1..31 with data = index → after the last commit, regs_flat[i] = i for all i ≥ 1; wr_ready stays 1 throughout.
- hold = 1, queue full with addr 7 and addr 9, then rst_n = 0 for one edge → regs 7 and 9 stay 0; pending = 0, busy = 0, wr_ready = 1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file write side.
// Imported by regfile_wr_demux and dec5to32.
package regfile_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    // One queued writeback: destination index and data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wq_entry_t;

endpackage

// File: rtl/regfile_wr_demux_dec.sv
// dec5to32: 5-bit index to 32-bit one-hot, all-zero when en is low.
// Ports: addr (index), en (gate), onehot (decoded bus).
module dec5to32
    import regfile_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic                  en,
    output logic [REG_COUNT-1:0]  onehot
);

    assign onehot = en ? (REG_COUNT'(1) << addr) : '0;

endmodule

// File: rtl/regfile_wr_demux.sv
// regfile_wr_demux: write side of the 32 x WIDTH register file with a
// 2-entry in-order writeback queue and one-hot commit steering.
// Ports: clk, rst_n (sync, active-low); wr_valid/wr_ready/wr_addr/wr_data
// request handshake; hold blocks commits; regs_flat exposes all registers;
// pending flags registers with queued writes; busy = queue not empty.
module regfile_wr_demux
    import regfile_pkg::*;
#(
    // Queue entries carry XLEN data bits, so WIDTH must not exceed XLEN.
    parameter int WIDTH = XLEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [REG_ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       hold,
    output logic [REG_COUNT*WIDTH-1:0] regs_flat,
    output logic [REG_COUNT-1:0]       pending,
    output logic                       busy
);

    logic [1:0]           count;
    logic                 head;
    logic                 tail;
    wq_entry_t            q [2];
    wq_entry_t            hd;
    logic [1:0]           qv;

    logic                 accept;
    logic                 enq;
    logic                 commit;

    logic [REG_COUNT-1:0] we;
    logic [REG_COUNT-1:0] pend0;
    logic [REG_COUNT-1:0] pend1;
    logic                 unused_we0;

    logic [WIDTH-1:0]     regs [1:REG_COUNT-1];

    // Ready depends on occupancy only, never on hold or a same-cycle commit.
    assign wr_ready = (count < 2'd2);
    assign busy     = (count != 2'd0);

    assign accept = wr_valid & wr_ready;
    // Writes to x0 complete the handshake but never occupy the queue.
    assign enq    = accept & (wr_addr != '0);
    assign commit = (count != 2'd0) & ~hold;

    assign hd = q[head];

    // Slot i is live when the queue is full, or holds the single entry.
    assign qv[0] = (count == 2'd2) | ((count == 2'd1) & ~head);
    assign qv[1] = (count == 2'd2) | ((count == 2'd1) & head);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
            q[0]  <= '0;
            q[1]  <= '0;
        end else begin
            if (enq) begin
                q[tail] <= '{addr: wr_addr, data: XLEN'(wr_data)};
                tail    <= ~tail;
            end
            if (commit) begin
                head <= ~head;
            end
            case ({enq, commit})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    dec5to32 u_dec_commit (
        .addr   (hd.addr),
        .en     (commit),
        .onehot (we)
    );

    dec5to32 u_dec_pend0 (
        .addr   (q[0].addr),
        .en     (qv[0]),
        .onehot (pend0)
    );

    dec5to32 u_dec_pend1 (
        .addr   (q[1].addr),
        .en     (qv[1]),
        .onehot (pend1)
    );

    // x0 has no storage, so its enable and pending bit are meaningless.
    assign unused_we0 = we[0];
    assign pending    = (pend0 | pend1) & 32'hFFFF_FFFE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (we[i]) begin
                    regs[i] <= WIDTH'(hd.data);
                end
            end
        end
    end

    assign regs_flat[0 +: WIDTH] = '0;

    for (genvar g = 1; g < REG_COUNT; g++) begin : g_flat
        assign regs_flat[g*WIDTH +: WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_regfile_wr_demux.sv
// Self-checking bench for regfile_wr_demux: vector table with
// hand-derived expectations plus a scoreboard queue of pending writes.
module tb_regfile_wr_demux;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [4:0]      wr_addr = '0;
    logic [W-1:0]    wr_data = '0;
    logic            hold = 1'b0;
    logic [32*W-1:0] regs_flat;
    logic [31:0]     pending;
    logic            busy;

    always #5 clk = ~clk;

    regfile_wr_demux #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .hold      (hold),
        .regs_flat (regs_flat),
        .pending   (pending),
        .busy      (busy)
    );

    typedef struct {
        logic [4:0]   addr;
        logic [W-1:0] data;
    } ent_t;

    typedef struct {
        logic         r;
        logic         v;
        logic [4:0]   a;
        logic [W-1:0] d;
        logic         h;
        logic         er;
        logic         eb;
        logic [31:0]  ep;
        int           ca;
        logic [W-1:0] cv;
    } vec_t;

    ent_t         sbq[$];
    logic [W-1:0] mregs [32];
    vec_t         tbl[$];
    int           checks = 0;
    int           failures = 0;

    function automatic logic [W-1:0] slice(input int i);
        return regs_flat[i*W +: W];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_model();
        logic [31:0]     ep;
        logic [32*W-1:0] ef;
        int              bad;
        ep = '0;
        foreach (sbq[k]) ep[sbq[k].addr] = 1'b1;
        chk("model_pending", 64'(pending), 64'(ep));
        chk("model_busy", 64'(busy), 64'(sbq.size() != 0));
        chk("model_ready", 64'(wr_ready), 64'(sbq.size() < 2));
        for (int i = 0; i < 32; i++) ef[i*W +: W] = mregs[i];
        checks++;
        if (regs_flat !== ef) begin
            bad = -1;
            for (int i = 0; i < 32; i++)
                if (bad < 0 && slice(i) !== mregs[i]) bad = i;
            failures++;
            $display("FAIL model_regs[%0d] got %h want %h",
                     bad, slice(bad), mregs[bad]);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [4:0] a,
                       input logic [W-1:0] d, input logic h);
        bit cm;
        bit ac;
        ent_t e;
        rst_n = r;
        wr_valid = v;
        wr_addr = a;
        wr_data = d;
        hold = h;
        cm = (sbq.size() > 0) && !h;
        ac = v && (sbq.size() < 2);
        @(posedge clk);
        if (!r) begin
            sbq.delete();
            for (int i = 0; i < 32; i++) mregs[i] = '0;
        end else begin
            if (cm) begin
                e = sbq.pop_front();
                mregs[e.addr] = e.data;
            end
            if (ac && a != 5'd0) sbq.push_back('{addr: a, data: d});
        end
        #1;
        chk_model();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = '0;

        tbl.push_back('{0,0,0,0,0, 1,0,0, 5,0});
        tbl.push_back('{0,0,0,0,0, 1,0,0, 0,0});
        tbl.push_back('{1,1,5,32'hDEADBEEF,0, 1,1,32'h20, 5,0});
        tbl.push_back('{1,0,0,0,0, 1,0,0, 5,32'hDEADBEEF});
        tbl.push_back('{1,1,0,32'hFFFFFFFF,0, 1,0,0, 0,0});
        tbl.push_back('{1,1,3,1,1, 1,1,32'h8, 3,0});
        tbl.push_back('{1,1,3,2,1, 0,1,32'h8, 3,0});
        tbl.push_back('{1,0,0,0,1, 0,1,32'h8, 3,0});
        tbl.push_back('{1,0,0,0,0, 1,1,32'h8, 3,1});
        tbl.push_back('{1,0,0,0,0, 1,0,0, 3,2});
        tbl.push_back('{1,1,7,32'h77,1, 1,1,32'h80, 7,0});
        tbl.push_back('{1,1,9,32'h99,1, 0,1,32'h280, 9,0});
        tbl.push_back('{0,0,0,0,1, 1,0,0, 7,0});
        tbl.push_back('{1,0,0,0,0, 1,0,0, 9,0});
        tbl.push_back('{1,0,0,0,0, 1,0,0, 7,0});

        foreach (tbl[n]) begin
            cyc(tbl[n].r, tbl[n].v, tbl[n].a, tbl[n].d, tbl[n].h);
            chk($sformatf("vec%0d_ready", n), 64'(wr_ready), 64'(tbl[n].er));
            chk($sformatf("vec%0d_busy", n), 64'(busy), 64'(tbl[n].eb));
            chk($sformatf("vec%0d_pending", n), 64'(pending), 64'(tbl[n].ep));
            chk($sformatf("vec%0d_reg%0d", n, tbl[n].ca),
                64'(slice(tbl[n].ca)), 64'(tbl[n].cv));
        end

        for (int i = 1; i < 32; i++) begin
            cyc(1, 1, 5'(i), W'(i), 0);
            chk($sformatf("b2b_ready%0d", i), 64'(wr_ready), 64'd1);
        end
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i < 32; i++)
            chk($sformatf("b2b_reg%0d", i), 64'(slice(i)), 64'(i));
        chk("b2b_reg0", 64'(slice(0)), 64'd0);

        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), W'($urandom),
                ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
